// File: rtl/xsw_nm_pkt_if.sv
// Crossbar port bundle.
//   slave  modport: switch-side view of the N inputs
//                   (vld_s, dat_s, lst_s, tgt_s in; gnt_s out)
//   master modport: switch-side view of the M outputs
//                   (vld_m, dat_m, lst_m out; gnt_m in)
interface xsw_nm_pkt_if #(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int DW = 8
);
  logic [N-1:0]         vld_s;
  logic [N-1:0][DW-1:0] dat_s;
  logic [N-1:0]         lst_s;
  logic [N-1:0][M-1:0]  tgt_s;
  logic [N-1:0]         gnt_s;

  logic [M-1:0]         vld_m;
  logic [M-1:0][DW-1:0] dat_m;
  logic [M-1:0]         lst_m;
  logic [M-1:0]         gnt_m;

  modport slave  (input vld_s, dat_s, lst_s, tgt_s, output gnt_s);
  modport master (output vld_m, dat_m, lst_m, input gnt_m);
endinterface

// File: rtl/xsw_nm_pkt.sv
// N-input x M-output packet crossbar. Each output owns a packet-locked
// arbiter (round-robin or fixed priority) feeding an OBUF_D-entry FIFO.
// Multi-beat packets are never interleaved on an output.
// Ports:
//   clk   clock
//   rstn  synchronous active-low reset
//   s_if  input side  (vld_s/dat_s/lst_s/tgt_s in, gnt_s out)
//   m_if  output side (vld_m/dat_m/lst_m out, gnt_m in)
//
// Per-output arbiter states:
//   state   | meaning
//   ST_IDLE | no packet in flight; pick a winner among requesters
//   ST_LOCK | packet from owner_q in flight; only owner may be granted
module xsw_nm_pkt #(
  parameter int N        = 2,
  parameter int M        = 2,
  parameter int DW       = 8,
  parameter int OBUF_D   = 2,
  parameter int ARB_MODE = 0
) (
  input  logic         clk,
  input  logic         rstn,
  xsw_nm_pkt_if.slave  s_if,
  xsw_nm_pkt_if.master m_if
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (OBUF_D > 1) ? $clog2(OBUF_D) : 1;
  localparam int CW = $clog2(OBUF_D + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} arb_st_e;

  arb_st_e              st_q [M];
  arb_st_e              st_d [M];
  logic [IW-1:0]        owner_q [M];
  logic [IW-1:0]        owner_d [M];
  logic [IW-1:0]        ptr_q [M];
  logic [IW-1:0]        ptr_d [M];
  logic [IW-1:0]        win_idx [M];
  logic [M-1:0]         win_vld;
  logic [M-1:0]         push;
  logic [M-1:0]         pop;
  logic [M-1:0][N-1:0]  req;
  logic [M-1:0][N-1:0]  gvec;
  logic [M-1:0][DW-1:0] wdat;
  logic [M-1:0]         wlst;
  logic [N-1:0]         gnt;

  logic [DW-1:0]        mem_dat [M][OBUF_D];
  logic                 mem_lst [M][OBUF_D];
  logic [AW-1:0]        rd_q [M];
  logic [AW-1:0]        wr_q [M];
  logic [CW-1:0]        cnt_q [M];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (int'(p) == OBUF_D - 1) ? '0 : AW'(p + 1'b1);
  endfunction

  always_comb begin
    for (int o = 0; o < M; o++)
      for (int i = 0; i < N; i++)
        req[o][i] = s_if.vld_s[i] & s_if.tgt_s[i][o];
  end

  always_comb begin
    for (int o = 0; o < M; o++) begin
      win_vld[o] = 1'b0;
      win_idx[o] = '0;
      st_d[o]    = st_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      gvec[o]    = '0;
      if (st_q[o] == ST_LOCK) begin
        if (req[o][owner_q[o]]) begin
          win_vld[o] = 1'b1;
          win_idx[o] = owner_q[o];
        end
      end else if (ARB_MODE == 1) begin
        // Descending scan: the last hit is the lowest requesting index.
        for (int i = N - 1; i >= 0; i--)
          if (req[o][i]) begin
            win_vld[o] = 1'b1;
            win_idx[o] = IW'(i);
          end
      end else begin
        // Descending offset scan: the last hit is the first requester at/after ptr.
        for (int k = N - 1; k >= 0; k--)
          if (req[o][(int'(ptr_q[o]) + k) % N]) begin
            win_vld[o] = 1'b1;
            win_idx[o] = IW'((int'(ptr_q[o]) + k) % N);
          end
      end
      // Full is judged on the registered count; a same-cycle pop does not help.
      push[o] = rstn & win_vld[o] & (cnt_q[o] < CW'(OBUF_D));
      wdat[o] = s_if.dat_s[win_idx[o]];
      wlst[o] = s_if.lst_s[win_idx[o]];
      if (push[o]) begin
        gvec[o][win_idx[o]] = 1'b1;
        if (wlst[o]) begin
          st_d[o] = ST_IDLE;
          if (ARB_MODE == 0)
            ptr_d[o] = IW'((int'(win_idx[o]) + 1) % N);
        end else begin
          st_d[o]    = ST_LOCK;
          owner_d[o] = win_idx[o];
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int o = 0; o < M; o++)
      gnt = gnt | gvec[o];
  end

  assign s_if.gnt_s = gnt;

  always_comb begin
    for (int o = 0; o < M; o++) begin
      m_if.vld_m[o] = (cnt_q[o] != '0);
      m_if.dat_m[o] = (cnt_q[o] != '0) ? mem_dat[o][rd_q[o]] : '0;
      m_if.lst_m[o] = (cnt_q[o] != '0) ? mem_lst[o][rd_q[o]] : 1'b0;
      pop[o]        = (cnt_q[o] != '0) & m_if.gnt_m[o];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int o = 0; o < M; o++) begin
        st_q[o]    <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < M; o++) begin
        st_q[o]    <= st_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int o = 0; o < M; o++) begin
        rd_q[o]  <= '0;
        wr_q[o]  <= '0;
        cnt_q[o] <= '0;
        for (int e = 0; e < OBUF_D; e++) begin
          mem_dat[o][e] <= '0;
          mem_lst[o][e] <= 1'b0;
        end
      end
    end else begin
      for (int o = 0; o < M; o++) begin
        if (push[o]) begin
          mem_dat[o][wr_q[o]] <= wdat[o];
          mem_lst[o][wr_q[o]] <= wlst[o];
          wr_q[o]             <= ptr_inc(wr_q[o]);
        end
        if (pop[o])
          rd_q[o] <= ptr_inc(rd_q[o]);
        if (push[o] && !pop[o])
          cnt_q[o] <= cnt_q[o] + 1'b1;
        else if (pop[o] && !push[o])
          cnt_q[o] <= cnt_q[o] - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chk_in
    a_tgt_onehot: assert property (@(posedge clk) disable iff (!rstn)
      s_if.vld_s[i] |-> $onehot(s_if.tgt_s[i]))
      else $error("tgt_s[%0d] not one-hot while valid", i);
  end

  for (genvar o = 0; o < M; o++) begin : g_chk_out
    a_tgt_stable: assert property (@(posedge clk) disable iff (!rstn)
      (st_q[o] == ST_LOCK && s_if.vld_s[owner_q[o]]) |-> s_if.tgt_s[owner_q[o]][o])
      else $error("target changed mid-packet at output %0d", o);
    a_one_grant: assert property (@(posedge clk) disable iff (!rstn)
      $onehot0(gvec[o]))
      else $error("output %0d granted more than one input", o);
    a_no_ovf: assert property (@(posedge clk) disable iff (!rstn)
      !(push[o] && cnt_q[o] == CW'(OBUF_D)))
      else $error("fifo overflow at output %0d", o);
    a_no_udf: assert property (@(posedge clk) disable iff (!rstn)
      !(pop[o] && cnt_q[o] == '0))
      else $error("fifo underflow at output %0d", o);
  end
endmodule

// File: tb/tb_xsw_nm_pkt.sv
// Bench for xsw_nm_pkt: dut0 is N=2/M=2 round-robin with 2-deep FIFOs,
// dut1 is N=3/M=2 fixed priority with 1-deep FIFOs.
module tb_xsw_nm_pkt;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  xsw_nm_pkt_if #(.N(2), .M(2), .DW(8)) if0 ();
  xsw_nm_pkt_if #(.N(3), .M(2), .DW(8)) if1 ();

  xsw_nm_pkt #(.N(2), .M(2), .DW(8), .OBUF_D(2), .ARB_MODE(0)) dut0 (
    .clk(clk), .rstn(rstn), .s_if(if0), .m_if(if0));
  xsw_nm_pkt #(.N(3), .M(2), .DW(8), .OBUF_D(1), .ARB_MODE(1)) dut1 (
    .clk(clk), .rstn(rstn), .s_if(if1), .m_if(if1));

  typedef struct {
    logic        d;    // 0 drives dut0, 1 drives dut1
    logic [2:0]  vld;
    logic [2:0]  lst;
    logic [5:0]  tgt;  // {tgt2, tgt1, tgt0}
    logic [23:0] dat;  // {dat2, dat1, dat0}
    logic [1:0]  gm;
    logic [2:0]  eg;   // expected gnt_s
    logic [1:0]  ev;   // expected vld_m
  } vec_t;

  typedef logic [8:0] sb_q_t [$];

  vec_t  vecs [$];
  sb_q_t sbq [4];
  int    total = 0;
  int    bad   = 0;

  task automatic add(input logic d, input logic [2:0] vld, input logic [2:0] lst,
                     input logic [5:0] tgt, input logic [23:0] dat, input logic [1:0] gm,
                     input logic [2:0] eg, input logic [1:0] ev);
    vec_t v;
    v.d = d; v.vld = vld; v.lst = lst; v.tgt = tgt; v.dat = dat;
    v.gm = gm; v.eg = eg; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input int qi, input logic [8:0] got);
    logic [8:0] want;
    if (sbq[qi].size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_pop q%0d: got %0h want none at %0t", qi, got, $time);
    end else begin
      want = sbq[qi].pop_front();
      chk($sformatf("sb_pop q%0d", qi), 32'(got), 32'(want));
    end
  endtask

  // Drives one cycle at negedge+1, checks at negedge+2, ends at next negedge+1.
  task automatic step(input vec_t v, input int k);
    int qi;
    if (!v.d) begin
      if0.vld_s = v.vld[1:0]; if0.lst_s = v.lst[1:0];
      if0.tgt_s = v.tgt[3:0]; if0.dat_s = v.dat[15:0]; if0.gnt_m = v.gm;
      if1.vld_s = '0; if1.gnt_m = 2'b11;
    end else begin
      if1.vld_s = v.vld; if1.lst_s = v.lst;
      if1.tgt_s = v.tgt; if1.dat_s = v.dat; if1.gnt_m = v.gm;
      if0.vld_s = '0; if0.gnt_m = 2'b11;
    end
    #1;
    if (!v.d) begin
      chk($sformatf("gnt_s v%0d", k), 32'(if0.gnt_s), 32'(v.eg));
      chk($sformatf("vld_m v%0d", k), 32'(if0.vld_m), 32'(v.ev));
    end else begin
      chk($sformatf("gnt_s v%0d", k), 32'(if1.gnt_s), 32'(v.eg));
      chk($sformatf("vld_m v%0d", k), 32'(if1.vld_m), 32'(v.ev));
    end
    for (int o = 0; o < 2; o++) begin
      if (if0.vld_m[o] && if0.gnt_m[o]) pop_chk(o, {if0.lst_m[o], if0.dat_m[o]});
      if (if1.vld_m[o] && if1.gnt_m[o]) pop_chk(2 + o, {if1.lst_m[o], if1.dat_m[o]});
    end
    for (int i = 0; i < 3; i++)
      if (v.eg[i]) begin
        qi = 2 * int'(v.d) + (v.tgt[2*i+1] ? 1 : 0);
        sbq[qi].push_back({v.lst[i], v.dat[8*i +: 8]});
      end
    @(negedge clk);
    #1;
  endtask

  task automatic run_vecs();
    for (int k = 0; k < vecs.size(); k++) step(vecs[k], k);
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with every input requesting.
    rstn = 1'b0;
    if0.vld_s = 2'b11; if0.lst_s = 2'b11; if0.tgt_s = 4'b0101; if0.dat_s = 16'h0000; if0.gnt_m = 2'b11;
    if1.vld_s = 3'b111; if1.lst_s = 3'b111; if1.tgt_s = 6'b010101; if1.dat_s = 24'h0; if1.gnt_m = 2'b11;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      #1;
      chk("rst gnt_s0", 32'(if0.gnt_s), 32'd0);
      chk("rst gnt_s1", 32'(if1.gnt_s), 32'd0);
      chk("rst vld_m0", 32'(if0.vld_m), 32'd0);
      chk("rst vld_m1", 32'(if1.vld_m), 32'd0);
      chk("rst dat_m0", 32'(if0.dat_m), 32'd0);
      chk("rst lst_m0", 32'(if0.lst_m), 32'd0);
    end
    rstn = 1'b1;

    // Round-robin: both inputs to out0, single-beat packets.
    add(0, 3'b011, 3'b011, 6'b000101, 24'h008101, 2'b11, 3'b001, 2'b00);
    add(0, 3'b011, 3'b011, 6'b000101, 24'h008102, 2'b11, 3'b010, 2'b01);
    add(0, 3'b011, 3'b011, 6'b000101, 24'h008202, 2'b11, 3'b001, 2'b01);
    add(0, 3'b011, 3'b011, 6'b000101, 24'h008203, 2'b11, 3'b010, 2'b01);
    add(0, 3'b001, 3'b011, 6'b000101, 24'h000003, 2'b11, 3'b001, 2'b01);
    add(0, 3'b000, 3'b000, 6'b000101, 24'h000000, 2'b11, 3'b000, 2'b01);
    add(0, 3'b000, 3'b000, 6'b000101, 24'h000000, 2'b11, 3'b000, 2'b00);
    // Packet lock: A0,A1,A2 from in0; B0 from in1 waits for A2.
    add(0, 3'b001, 3'b000, 6'b000101, 24'h0000A0, 2'b11, 3'b001, 2'b00);
    add(0, 3'b011, 3'b010, 6'b000101, 24'h00B0A1, 2'b11, 3'b001, 2'b01);
    add(0, 3'b011, 3'b011, 6'b000101, 24'h00B0A2, 2'b11, 3'b001, 2'b01);
    add(0, 3'b010, 3'b010, 6'b000101, 24'h00B000, 2'b11, 3'b010, 2'b01);
    add(0, 3'b000, 3'b000, 6'b000101, 24'h000000, 2'b11, 3'b000, 2'b01);
    // Bubble inside a locked packet keeps in1 held off.
    add(0, 3'b001, 3'b000, 6'b000101, 24'h0000C0, 2'b11, 3'b001, 2'b00);
    add(0, 3'b010, 3'b010, 6'b000101, 24'h00D000, 2'b11, 3'b000, 2'b01);
    add(0, 3'b011, 3'b011, 6'b000101, 24'h00D0C1, 2'b11, 3'b001, 2'b00);
    add(0, 3'b010, 3'b010, 6'b000101, 24'h00D000, 2'b11, 3'b010, 2'b01);
    add(0, 3'b000, 3'b000, 6'b000101, 24'h000000, 2'b11, 3'b000, 2'b01);
    // Backpressure: out0 stalled five cycles, FIFO holds exactly two beats.
    add(0, 3'b001, 3'b001, 6'b000101, 24'h000031, 2'b10, 3'b001, 2'b00);
    add(0, 3'b001, 3'b001, 6'b000101, 24'h000032, 2'b10, 3'b001, 2'b01);
    add(0, 3'b001, 3'b001, 6'b000101, 24'h000033, 2'b10, 3'b000, 2'b01);
    add(0, 3'b001, 3'b001, 6'b000101, 24'h000033, 2'b10, 3'b000, 2'b01);
    add(0, 3'b001, 3'b001, 6'b000101, 24'h000033, 2'b10, 3'b000, 2'b01);
    add(0, 3'b001, 3'b001, 6'b000101, 24'h000033, 2'b11, 3'b000, 2'b01);
    add(0, 3'b001, 3'b001, 6'b000101, 24'h000033, 2'b11, 3'b001, 2'b01);
    add(0, 3'b000, 3'b000, 6'b000101, 24'h000000, 2'b11, 3'b000, 2'b01);
    // Parallel: in0->out1, in1->out0.
    add(0, 3'b011, 3'b011, 6'b000110, 24'h006171, 2'b11, 3'b011, 2'b00);
    add(0, 3'b011, 3'b011, 6'b000110, 24'h006272, 2'b11, 3'b011, 2'b11);
    add(0, 3'b011, 3'b011, 6'b000110, 24'h006373, 2'b11, 3'b011, 2'b11);
    add(0, 3'b000, 3'b000, 6'b000110, 24'h000000, 2'b11, 3'b000, 2'b11);
    add(0, 3'b000, 3'b000, 6'b000110, 24'h000000, 2'b11, 3'b000, 2'b00);
    // Fixed priority with a 1-deep FIFO: in0 wins every other cycle.
    add(1, 3'b111, 3'b111, 6'b010101, 24'h615141, 2'b11, 3'b001, 2'b00);
    add(1, 3'b111, 3'b111, 6'b010101, 24'h615142, 2'b11, 3'b000, 2'b01);
    add(1, 3'b111, 3'b111, 6'b010101, 24'h615142, 2'b11, 3'b001, 2'b00);
    add(1, 3'b111, 3'b111, 6'b010101, 24'h615143, 2'b11, 3'b000, 2'b01);
    add(1, 3'b111, 3'b111, 6'b010101, 24'h615143, 2'b11, 3'b001, 2'b00);
    add(1, 3'b110, 3'b111, 6'b010101, 24'h615100, 2'b11, 3'b000, 2'b01);
    add(1, 3'b110, 3'b111, 6'b010101, 24'h615100, 2'b11, 3'b010, 2'b00);
    add(1, 3'b100, 3'b111, 6'b010101, 24'h610000, 2'b11, 3'b000, 2'b01);
    add(1, 3'b100, 3'b111, 6'b010101, 24'h610000, 2'b11, 3'b100, 2'b00);
    add(1, 3'b000, 3'b000, 6'b010101, 24'h000000, 2'b11, 3'b000, 2'b01);
    add(1, 3'b000, 3'b000, 6'b010101, 24'h000000, 2'b11, 3'b000, 2'b00);
    // Start a packet on dut0 that reset will cut short.
    add(0, 3'b001, 3'b000, 6'b000101, 24'h0000E0, 2'b11, 3'b001, 2'b00);
    run_vecs();

    // Reset mid-packet: lock and FIFO contents are dropped.
    rstn = 1'b0;
    if0.vld_s = 2'b11; if0.lst_s = 2'b10; if0.tgt_s = 4'b0101; if0.dat_s = 16'hF0E1;
    if1.vld_s = '0;
    #1;
    chk("midrst gnt_s0", 32'(if0.gnt_s), 32'd0);
    sbq[0].delete();
    @(negedge clk);
    #1;
    chk("midrst vld_m0", 32'(if0.vld_m), 32'd0);
    chk("midrst dat_m0", 32'(if0.dat_m), 32'd0);
    rstn = 1'b1;
    add(0, 3'b010, 3'b010, 6'b000101, 24'h00F000, 2'b11, 3'b010, 2'b00);
    add(0, 3'b000, 3'b000, 6'b000101, 24'h000000, 2'b11, 3'b000, 2'b01);
    add(0, 3'b000, 3'b000, 6'b000101, 24'h000000, 2'b11, 3'b000, 2'b00);
    run_vecs();

    for (int q = 0; q < 4; q++)
      chk($sformatf("sb_left q%0d", q), 32'(sbq[q].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
